divide_result_display: RTL and testbench
========================================

Name: divide_result_display

Overview:
- Consumes the quotient/remainder pair produced by the 8-bit divider stage, including its divide-by-zero flag.
- Converts both values to BCD with a sequential shift-add-3 (double-dabble) engine.
- Time-multiplexes the 8-digit common-anode seven-segment display on the board: quotient on digits 7..4, remainder on digits 3..0.

Parameters:
- WIDTH, 8, bit width of quotient and remainder; legal range 1..13 so each value fits in 4 BCD digits.
- SCAN_DIV, 100000, clk cycles each digit stays lit; legal minimum 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to latch and convert the inputs.
- quotient  input  WIDTH  divider quotient.
- remainder  input  WIDTH  divider remainder.
- div_zero  input  1  divisor was zero; the divider outputs all-ones in that case.
- busy  output  1  conversion in progress.
- done  output  1  one-cycle pulse when the new result is on the display.
- an  output  8  digit enables, active low; bit i = digit i.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.

Behaviour:
- Reset (async, rst_n=0):
  - busy=0, done=0.
  - an=8'hFF, seg=7'h7F, dp=1.
  - Displayed BCD registers cleared to 0; error flag cleared.
  - FSM goes to IDLE; scan index 0; prescaler 0.
- Reset release: at the first clk edge an=8'hFE. Scanning then runs continuously.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1.
  - On terminal count, the prescaler wraps and the digit index advances mod 8 (7 wraps to 0).
  - an, seg and dp are registered.
- FSM states: IDLE, CONV, DONE.
  - IDLE: start=1 latches quotient, remainder and div_zero, clears the working BCD registers, and moves to CONV.
  - CONV: runs exactly WIDTH iterations. Each iteration adds 3 to any working nibble >=5, then shifts one binary MSB into the BCD chain. Quotient and remainder are processed in parallel. The state is held for WIDTH cycles even when div_zero=1, so latency is uniform.
  - DONE: copies the working BCD and the error flag into the displayed registers in one cycle (atomic update). done=1 for this cycle only, then returns to IDLE.
- Timing: start sampled at edge k.
  - busy=1 from edge k+1 through edge k+WIDTH.
  - done=1 and new display data appear from edge k+WIDTH+1.
- start while busy or in DONE: ignored, not queued.
- The display keeps showing the previous result throughout a conversion.
- Segment codes: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, E=06, blank=7F (all hex).
- dp=0 only while digit 4 is lit (quotient/remainder separator).
- Error display (latched div_zero=1): digit 4 and digit 0 show E; all other digits blank.
- Reset during CONV or DONE: immediate return to the reset state. No done pulse; the display shows cleared values.

Optional Feature:
- Macro: BLANK_LZ_EN.
- Defined: leading zeros in each 4-digit field show blank (7F). Digit 4 and digit 0 are always shown, so a value of 0 displays as a single 0.
- Undefined: all 8 digits show their BCD value, including leading zeros.
- Error display is identical in both builds.

Test Plan (WIDTH=8, SCAN_DIV=4, BLANK_LZ_EN defined unless noted):
1. Hold rst_n=0 -> an=FF, seg=7F, dp=1, busy=0, done=0. Release -> an=FE at the next edge, FD 4 cycles later, 7F after 8 digits, FE again after 32 cycles.
2. start with quotient=28, remainder=4, div_zero=0 -> busy for 8 cycles, done pulse 9 cycles after start. Scanning then gives digit5=24, digit4=00 with dp=0, digit0=19, others 7F.
3. start with quotient=255, remainder=255, div_zero=1 -> same latency. Digit4=06 with dp=0, digit0=06, others 7F.
4. start with 28/4, then start again with 99/9 three cycles later -> the second start is ignored, exactly one done pulse, and the display shows 28/4.
5. Assert rst_n for one cycle mid-CONV -> busy=0, no done pulse. The display shows digit4=40, digit0=40, others 7F.
6. Build without BLANK_LZ_EN, start with quotient=0, remainder=0 -> after done, all 8 digits show 40.

Source files
------------

// File: rtl/divide_result_display.sv
// divide_result_display: converts the divider's quotient/remainder to BCD with a
// sequential shift-add-3 engine and scans them onto an 8-digit common-anode
// seven-segment display (quotient on digits 7..4, remainder on digits 3..0).
// Optional build macro BLANK_LZ_EN: blank leading zeros in each 4-digit field.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; display shows the last result
// CONV  | WIDTH shift-add-3 iterations on quotient and remainder
// DONE  | copy working BCD and error flag to the display registers
module divide_result_display #(
  parameter int WIDTH    = 8,
  parameter int SCAN_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] quotient,
  input  logic [WIDTH-1:0] remainder,
  input  logic             div_zero,
  output logic             busy,
  output logic             done,
  output logic [7:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);

  localparam int PW = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

  state_t           state;
  logic [3:0]       iter_cnt;
  logic [WIDTH-1:0] q_bin, r_bin;
  logic [15:0]      q_bcd, r_bcd;
  logic             work_err;
  logic [15:0]      disp_q, disp_r;
  logic             disp_err;

  logic [PW-1:0]    pre;
  logic [2:0]       idx;
  logic [15:0]      field, upper;
  logic             lead_blank;
  logic [6:0]       seg_next;

  // One double-dabble iteration: correct every nibble >= 5, then shift in one bit.
  function automatic logic [15:0] dabble(input logic [15:0] bcd, input logic bit_in);
    logic [15:0] adj;
    adj = bcd;
    for (int i = 0; i < 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return {adj[14:0], bit_in};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'h40;
      4'd1:    seg_code = 7'h79;
      4'd2:    seg_code = 7'h24;
      4'd3:    seg_code = 7'h30;
      4'd4:    seg_code = 7'h19;
      4'd5:    seg_code = 7'h12;
      4'd6:    seg_code = 7'h02;
      4'd7:    seg_code = 7'h78;
      4'd8:    seg_code = 7'h00;
      4'd9:    seg_code = 7'h10;
      default: seg_code = 7'h7F;
    endcase
  endfunction

  // Conversion FSM; display registers change only in DONE so updates are atomic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      iter_cnt <= '0;
      q_bin    <= '0;
      r_bin    <= '0;
      q_bcd    <= '0;
      r_bcd    <= '0;
      work_err <= 1'b0;
      disp_q   <= '0;
      disp_r   <= '0;
      disp_err <= 1'b0;
    end else begin
      busy <= (state == S_CONV);
      done <= (state == S_DONE);
      case (state)
        S_IDLE: begin
          if (start) begin
            q_bin    <= quotient;
            r_bin    <= remainder;
            work_err <= div_zero;
            q_bcd    <= '0;
            r_bcd    <= '0;
            iter_cnt <= 4'(WIDTH - 1);
            state    <= S_CONV;
          end
        end
        S_CONV: begin
          q_bcd    <= dabble(q_bcd, q_bin[WIDTH-1]);
          r_bcd    <= dabble(r_bcd, r_bin[WIDTH-1]);
          q_bin    <= q_bin << 1;
          r_bin    <= r_bin << 1;
          iter_cnt <= iter_cnt - 4'd1;
          if (iter_cnt == 4'd0) state <= S_DONE;
        end
        S_DONE: begin
          disp_q   <= q_bcd;
          disp_r   <= r_bcd;
          disp_err <= work_err;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Segment pattern for the digit currently selected by the scan index.
  always_comb begin
    field = idx[2] ? disp_q : disp_r;
    upper = field >> {idx[1:0], 2'b00};
`ifdef BLANK_LZ_EN
    lead_blank = (idx[1:0] != 2'd0) && (upper == 16'd0);
`else
    lead_blank = 1'b0;
`endif
    if (disp_err)        seg_next = (idx[1:0] == 2'd0) ? 7'h06 : 7'h7F;
    else if (lead_blank) seg_next = 7'h7F;
    else                 seg_next = seg_code(upper[3:0]);
  end

  // Free-running digit scan with registered anode, segment and decimal-point drives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
      an  <= 8'hFF;
      seg <= 7'h7F;
      dp  <= 1'b1;
    end else begin
      if (pre == PW'(SCAN_DIV - 1)) begin
        pre <= '0;
        idx <= idx + 3'd1;
      end else begin
        pre <= pre + 1'b1;
      end
      an  <= ~(8'd1 << idx);
      seg <= seg_next;
      dp  <= (idx != 3'd4);
    end
  end

endmodule

// File: tb/tb_divide_result_display.sv
// Self-checking bench for divide_result_display (WIDTH=8, SCAN_DIV=4) against a
// decimal-arithmetic reference model of the displayed digits.
module tb_divide_result_display;

  localparam int WIDTH    = 8;
  localparam int SCAN_DIV = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] quotient = '0;
  logic [WIDTH-1:0] remainder = '0;
  logic             div_zero = 1'b0;
  logic             busy, done, dp;
  logic [7:0]       an;
  logic [6:0]       seg;

  int tests_run = 0;
  int tests_failed = 0;

  int m_q = 0;
  int m_r = 0;
  bit m_err = 1'b0;

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  int pow10 [4] = '{1, 10, 100, 1000};

  divide_result_display #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .quotient(quotient),
    .remainder(remainder), .div_zero(div_zero), .busy(busy), .done(done),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] exp_seg(int i);
    int v, p, d;
    if (m_err) return (i == 4 || i == 0) ? 7'h06 : 7'h7F;
    v = (i >= 4) ? m_q : m_r;
    p = i % 4;
    d = (v / pow10[p]) % 10;
`ifdef BLANK_LZ_EN
    if (p > 0 && v < pow10[p]) return 7'h7F;
`endif
    return seg_tab[d];
  endfunction

  task automatic check_display(string name);
    logic [7:0] seen;
    seen = '0;
    repeat (40) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        if (an === ~(8'd1 << i)) begin
          seen[i] = 1'b1;
          tests_run++;
          if (seg !== exp_seg(i) || dp !== (i == 4 ? 1'b0 : 1'b1)) begin
            tests_failed++;
            $display("FAIL %s digit%0d: seg=%h dp=%b, required seg=%h dp=%b",
                     name, i, seg, dp, exp_seg(i), (i == 4 ? 1'b0 : 1'b1));
          end
        end
      end
    end
    tests_run++;
    if (seen !== 8'hFF) begin
      tests_failed++;
      $display("FAIL %s scan_coverage: digits seen=%h, required FF", name, seen);
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp_an;
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b busy=%b done=%b, required FF 7F 1 0 0",
               an, seg, dp, busy, done);
    end
    rst_n = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      @(posedge clk);
      #1;
      exp_an = ~(8'd1 << (((n - 1) / SCAN_DIV) % 8));
      tests_run++;
      if (an !== exp_an) begin
        tests_failed++;
        $display("FAIL scan_after_reset edge%0d: an=%h, required %h", n, an, exp_an);
      end
    end
  endtask

  // Start at a negedge; check busy/done latency; optionally a second start at cycle 'again_at'.
  task automatic test_conv(string name, int q, int r, bit err, int again_at);
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; quotient = WIDTH'(q); remainder = WIDTH'(r); div_zero = err;
    @(posedge clk);
    for (int n = 0; n <= WIDTH + 6; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) dones++;
      tests_run++;
      if (busy !== (n >= 1 && n <= WIDTH) || done !== (n == WIDTH + 1)) begin
        tests_failed++;
        $display("FAIL %s timing n=%0d: busy=%b done=%b, required busy=%b done=%b",
                 name, n, busy, done, (n >= 1 && n <= WIDTH), (n == WIDTH + 1));
      end
      if (n == again_at - 1) begin
        start = 1'b1; quotient = 8'd99; remainder = 8'd9; div_zero = 1'b0;
      end
    end
    tests_run++;
    if (dones != 1) begin
      tests_failed++;
      $display("FAIL %s done_count: %0d pulses, required 1", name, dones);
    end
    m_q = q; m_r = r; m_err = err;
    check_display(name);
  endtask

  task automatic test_basic();
    test_conv("q28_r4", 28, 4, 1'b0, -10);
    test_conv("div_zero", 255, 255, 1'b1, -10);
    test_conv("zero_zero", 0, 0, 1'b0, -10);
  endtask

  task automatic test_back_to_back();
    test_conv("ignored_start", 28, 4, 1'b0, 3);
  endtask

  task automatic test_random();
    int q, r;
    bit e;
    for (int k = 0; k < 6; k++) begin
      e = ($urandom_range(0, 3) == 0);
      q = e ? 255 : int'($urandom_range(0, 255));
      r = e ? 255 : int'($urandom_range(0, 255));
      test_conv($sformatf("random%0d", k), q, r, e, -10);
    end
  endtask

  task automatic test_reset_mid_conv();
    int dones;
    dones = 0;
    @(negedge clk);
    start = 1'b1; quotient = 8'd123; remainder = 8'd45; div_zero = 1'b0;
    @(posedge clk);
    repeat (3) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || an !== 8'hFF) begin
      tests_failed++;
      $display("FAIL reset_mid_conv: busy=%b an=%h, required busy=0 an=FF", busy, an);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    tests_run++;
    if (dones != 0) begin
      tests_failed++;
      $display("FAIL reset_mid_conv activity: %0d busy/done cycles, required 0", dones);
    end
    m_q = 0; m_r = 0; m_err = 1'b0;
    check_display("reset_mid_conv");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_random();
    test_reset_mid_conv();
    test_conv("after_reset", 28, 4, 1'b0, -10);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
